sp_ctrl: RTL
============

Name: sp_ctrl

Overview:
- Per-core instruction sequencer directly upstream of spcore.
- Accepts one 32-bit SP instruction through a valid/ready handshake and decodes it.
- Steps spcore through its source-read, execute, memory and write-back cycles by driving x/y/z/I/aluc/s2/reg_we, plus mem_we for the local data port.
- Signals retirement to the warp scheduler.

Parameters:
- INSTR_W, 32, instruction width. Fields: opcode[31:28], x[27:24], y[23:20], z[19:16], imm[15:0].
- CNT_W, 16, width of the performance counters (optional feature only).

Ports:
- clk  input  1  core clock, rising edge
- reset  input  1  synchronous, active-high
- instr  input  INSTR_W  instruction word
- instr_valid  input  1  instr is valid this cycle
- instr_ready  output  1  controller can accept an instruction
- done  output  1  one-cycle pulse when the instruction retires
- illegal  output  1  one-cycle pulse on an undefined opcode
- halted  output  1  HALT executed; sticky until reset
- en  output  1  spcore enable
- x, y, z  output  4 each  register indices to spcore
- I  output  16  immediate to spcore
- aluc  output  4  ALU opcode, `ALUC_* codes from constants.v
- s2  output  2  write-back mux select: `MuxD_fromI, `MuxD_fromALU or `MuxD_fromMem
- reg_we  output  1  register-file write enable
- mem_we  output  1  data-memory write enable (STORE)

Behaviour:
- Opcode map:
  - 0 NOP
  - 1 LOADI
  - 2 ADD
  - 3 MUL
  - 4 MAD
  - 5 LOADC_ID
  - 6 LOADC_N
  - 7 CLEAR
  - 8 INC
  - 9 LOAD
  - 10 STORE
  - 15 HALT
  - 11–14 are illegal.
- Reset values:
  - State IDLE.
  - x, y, z, I = 0.
  - aluc = `ALUC_CLEAR, s2 = `MuxD_fromALU.
  - reg_we, mem_we, done, illegal, halted = 0.
  - en = 1.
- FSM states: IDLE, READ, EXEC, MEM, WB, HALT.
- All outputs are registered.
- x/y/z/I are captured on accept and held constant until the next accept.
- IDLE:
  - instr_ready = 1.
  - On instr_valid, latch the fields and go to READ.
  - No accept in any other state; instr_ready = 0 outside IDLE.
- READ (source operand read): reg_we = 0, mem_we = 0. Next state:
  - LOADI → WB, with s2 = `MuxD_fromI and aluc = `ALUC_CLEAR.
  - ADD/MUL/MAD/LOADC_ID/LOADC_N/CLEAR/INC → EXEC.
  - LOAD/STORE → MEM.
  - NOP → IDLE, with done pulse.
  - HALT → HALT.
  - Illegal → IDLE, with done and illegal pulsing together.
- EXEC:
  - aluc set to the matching `ALUC_* code; s2 = `MuxD_fromALU; reg_we = 0.
  - Next state WB.
- MEM:
  - STORE: aluc = `ALUC_ADD (address = R[y]), mem_we = 1 for exactly this one cycle, then IDLE with done.
  - LOAD: s2 = `MuxD_fromMem, mem_we = 0, then WB.
- WB:
  - reg_we = 1 for exactly one cycle; aluc and s2 held from the previous state.
  - Next state IDLE.
  - done pulses in the same cycle reg_we is high.
- HALT:
  - halted = 1, en = 0, instr_ready = 0.
  - Stays in HALT until reset; done pulses once on entry.
- Latency, accept edge to done:
  - NOP: 1 cycle.
  - LOADI: 2 cycles.
  - ALU ops: 3 cycles.
  - STORE: 2 cycles.
  - LOAD: 3 cycles.
- Back-to-back: done and instr_ready are high in the same cycle the controller returns to IDLE. Zero-bubble issue is not required; there is one IDLE cycle between instructions.
- reg_we and mem_we are never high together, and never high outside WB/MEM.
- Reset mid-operation: on the next edge, go to IDLE with all enables low. No partial write is issued after reset is sampled.
- instr_valid while not ready: ignored. The upstream source must hold instr stable until it sees ready.

Optional Feature:
- Macro: SPCTRL_PERF_EN.
- When defined, two output ports are added:
  - retired [CNT_W-1:0]: increments on every done pulse, illegal instructions included.
  - busy_cycles [CNT_W-1:0]: increments every cycle the state is not IDLE or HALT.
- Both counters reset to 0 and wrap modulo 2^CNT_W.
- Without the macro, neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- LOADI x=0 imm=11, then LOADI x=1 imm=20 → each shows done 2 cycles after accept; reg_we high exactly 1 cycle with s2=`MuxD_fromI; spcore R[0]=11, R[1]=20.
- ADD x=2 y=0 z=1, then MAD x=2 y=0 z=1 → done 3 cycles after each accept; aluc=`ALUC_ADD then `ALUC_MAD during EXEC/WB; R[2]=31, then R[2]=251.
- STORE x=2 y=0, then LOAD x=3 y=0 → mem_we high exactly 1 cycle and reg_we stays 0 for STORE; LOAD reg_we in WB with s2=`MuxD_fromMem; R[3]=251.
- Opcode 12, then NOP → illegal and done pulse together 1 cycle after accept; no reg_we/mem_we; instr_ready returns 1.
- Reset asserted during the EXEC cycle of MUL x=2 → next edge in IDLE, reg_we never asserted, R[2] unchanged, instr_ready=1.
- HALT, then instr_valid held high → halted=1, en=0, instr_ready stays 0 for 10 cycles; reset clears halted. With SPCTRL_PERF_EN defined, after this sequence retired counts each retired instruction.

Source files
------------

// File: rtl/sp_ctrl.sv
// sp_ctrl: per-core instruction sequencer sitting directly upstream of spcore.
// It accepts one SP instruction over valid/ready and walks spcore through the
// READ / EXEC / MEM / WB cycles, then signals retirement to the warp scheduler.
//
// Every output is registered. The control fields of a state are computed while
// that state is current, so they appear on the ports one cycle later. As a
// result, the reg_we / mem_we / done pulses line up with the cycle in which
// the controller is back in IDLE with instr_ready high.
//
// Optional feature: define SPCTRL_PERF_EN to add the retired / busy_cycles
// performance counters (CNT_W bits wide, wrapping).
//
// The ALUC_* and MuxD_* codes come from constants.v. The fallback values below
// apply only when that file is not part of the compile.

`ifndef ALUC_CLEAR
`define ALUC_CLEAR    4'd0
`endif
`ifndef ALUC_ADD
`define ALUC_ADD      4'd1
`endif
`ifndef ALUC_MUL
`define ALUC_MUL      4'd2
`endif
`ifndef ALUC_MAD
`define ALUC_MAD      4'd3
`endif
`ifndef ALUC_LOADC_ID
`define ALUC_LOADC_ID 4'd4
`endif
`ifndef ALUC_LOADC_N
`define ALUC_LOADC_N  4'd5
`endif
`ifndef ALUC_INC
`define ALUC_INC      4'd6
`endif
`ifndef MuxD_fromI
`define MuxD_fromI    2'd0
`endif
`ifndef MuxD_fromALU
`define MuxD_fromALU  2'd1
`endif
`ifndef MuxD_fromMem
`define MuxD_fromMem  2'd2
`endif

module sp_ctrl #(
    parameter int INSTR_W = 32
`ifdef SPCTRL_PERF_EN
    ,
    parameter int CNT_W   = 16
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic               done,
    output logic               illegal,
    output logic               halted,
    output logic               en,
    output logic [3:0]         x,
    output logic [3:0]         y,
    output logic [3:0]         z,
    output logic [15:0]        I,
    output logic [3:0]         aluc,
    output logic [1:0]         s2,
    output logic               reg_we,
    output logic               mem_we
`ifdef SPCTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]   retired,
    output logic [CNT_W-1:0]   busy_cycles
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        EXEC,
        MEM,
        WB,
        HALT
    } state_e;

    localparam logic [3:0] OP_NOP      = 4'd0;
    localparam logic [3:0] OP_LOADI    = 4'd1;
    localparam logic [3:0] OP_ADD      = 4'd2;
    localparam logic [3:0] OP_MUL      = 4'd3;
    localparam logic [3:0] OP_MAD      = 4'd4;
    localparam logic [3:0] OP_LOADC_ID = 4'd5;
    localparam logic [3:0] OP_LOADC_N  = 4'd6;
    localparam logic [3:0] OP_CLEAR    = 4'd7;
    localparam logic [3:0] OP_INC      = 4'd8;
    localparam logic [3:0] OP_LOAD     = 4'd9;
    localparam logic [3:0] OP_STORE    = 4'd10;
    localparam logic [3:0] OP_HALT     = 4'd15;

    state_e      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [3:0]  x_q, x_d;
    logic [3:0]  y_q, y_d;
    logic [3:0]  z_q, z_d;
    logic [15:0] imm_q, imm_d;
    logic [3:0]  aluc_q, aluc_d;
    logic [1:0]  s2_q, s2_d;
    logic        reg_we_q, reg_we_d;
    logic        mem_we_q, mem_we_d;
    logic        done_q, done_d;
    logic        illegal_q, illegal_d;
    logic        halted_q, halted_d;
    logic        en_q, en_d;
    logic        ready_q, ready_d;

    // ALU operation for each opcode that passes through EXEC.
    function automatic logic [3:0] alu_code(input logic [3:0] op);
        case (op)
            OP_ADD:      alu_code = `ALUC_ADD;
            OP_MUL:      alu_code = `ALUC_MUL;
            OP_MAD:      alu_code = `ALUC_MAD;
            OP_LOADC_ID: alu_code = `ALUC_LOADC_ID;
            OP_LOADC_N:  alu_code = `ALUC_LOADC_N;
            OP_INC:      alu_code = `ALUC_INC;
            default:     alu_code = `ALUC_CLEAR;
        endcase
    endfunction

    // Next-state and next-output decode for the sequencer FSM.
    always_comb begin
        // NOTE: every signal written here gets a default first. A path that
        // leaves a signal unassigned would infer a latch.
        state_d   = state_q;
        op_d      = op_q;
        x_d       = x_q;
        y_d       = y_q;
        z_d       = z_q;
        imm_d     = imm_q;
        aluc_d    = aluc_q;
        s2_d      = s2_q;
        halted_d  = halted_q;
        en_d      = en_q;
        reg_we_d  = 1'b0;
        mem_we_d  = 1'b0;
        done_d    = 1'b0;
        illegal_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (instr_valid && ready_q) begin
                    op_d    = instr[31:28];
                    x_d     = instr[27:24];
                    y_d     = instr[23:20];
                    z_d     = instr[19:16];
                    imm_d   = instr[15:0];
                    state_d = READ;
                end
            end
            READ: begin
                case (op_q)
                    OP_NOP: begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                    OP_LOADI: begin
                        s2_d    = `MuxD_fromI;
                        aluc_d  = `ALUC_CLEAR;
                        state_d = WB;
                    end
                    OP_ADD, OP_MUL, OP_MAD, OP_LOADC_ID,
                    OP_LOADC_N, OP_CLEAR, OP_INC: begin
                        state_d = EXEC;
                    end
                    OP_LOAD, OP_STORE: begin
                        state_d = MEM;
                    end
                    OP_HALT: begin
                        done_d   = 1'b1;
                        halted_d = 1'b1;
                        en_d     = 1'b0;
                        state_d  = HALT;
                    end
                    default: begin
                        done_d    = 1'b1;
                        illegal_d = 1'b1;
                        state_d   = IDLE;
                    end
                endcase
            end
            EXEC: begin
                aluc_d  = alu_code(op_q);
                s2_d    = `MuxD_fromALU;
                state_d = WB;
            end
            MEM: begin
                if (op_q == OP_STORE) begin
                    // The ALU forms the address R[y]; the data port writes once.
                    aluc_d   = `ALUC_ADD;
                    mem_we_d = 1'b1;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else begin
                    s2_d    = `MuxD_fromMem;
                    state_d = WB;
                end
            end
            WB: begin
                reg_we_d = 1'b1;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    // State and registered-output flops with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples values from before the edge.
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= OP_NOP;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            imm_q     <= '0;
            aluc_q    <= `ALUC_CLEAR;
            s2_q      <= `MuxD_fromALU;
            reg_we_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            halted_q  <= 1'b0;
            en_q      <= 1'b1;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            x_q       <= x_d;
            y_q       <= y_d;
            z_q       <= z_d;
            imm_q     <= imm_d;
            aluc_q    <= aluc_d;
            s2_q      <= s2_d;
            reg_we_q  <= reg_we_d;
            mem_we_q  <= mem_we_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
            halted_q  <= halted_d;
            en_q      <= en_d;
            ready_q   <= ready_d;
        end
    end

    assign instr_ready = ready_q;
    assign done        = done_q;
    assign illegal     = illegal_q;
    assign halted      = halted_q;
    assign en          = en_q;
    assign x           = x_q;
    assign y           = y_q;
    assign z           = z_q;
    assign I           = imm_q;
    assign aluc        = aluc_q;
    assign s2          = s2_q;
    assign reg_we      = reg_we_q;
    assign mem_we      = mem_we_q;

`ifdef SPCTRL_PERF_EN
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [CNT_W-1:0] busy_q, busy_d;

    // Counter increments: retirements step in the same edge that raises done.
    always_comb begin
        retired_d = retired_q;
        busy_d    = busy_q;
        if (done_d) begin
            retired_d = retired_q + CNT_W'(1);
        end
        if (state_q != IDLE && state_q != HALT) begin
            busy_d = busy_q + CNT_W'(1);
        end
    end

    // Performance counter flops; both wrap naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_q <= '0;
            busy_q    <= '0;
        end else begin
            retired_q <= retired_d;
            busy_q    <= busy_d;
        end
    end

    assign retired     = retired_q;
    assign busy_cycles = busy_q;
`endif

endmodule
